// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier (unsigned or Baugh-Wooley signed) with valid/ready.
// Define WALLACE_MULT_FINAL_ADD_EN to add a final-adder stage that drives prod; otherwise prod is 0.
module wallace_mult_pipe #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r1,
    output logic [2*WIDTH-1:0] r2,
    output logic [2*WIDTH-1:0] prod
);

    localparam int PW = 2 * WIDTH;
    // Column heights never exceed WIDTH during reduction; two spare slots keep every index in range.
    localparam int H  = WIDTH + 2;

    function automatic logic [2*PW-1:0] wallace_tree(input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y,
                                                     input logic             sgn);
        logic          bits [PW][H];
        logic          nxt  [PW][H];
        int            cnt  [PW];
        int            ncnt [PW];
        int            maxh;
        int            base;
        logic          pp;
        logic [PW-1:0] row1;
        logic [PW-1:0] row2;

        for (int c = 0; c < PW; c++) begin
            cnt[c]  = 0;
            ncnt[c] = 0;
            for (int k = 0; k < H; k++) begin
                bits[c][k] = 1'b0;
                nxt[c][k]  = 1'b0;
            end
        end

        // Baugh-Wooley: cross terms involving exactly one sign bit are inverted.
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp = x[i] & y[j];
                if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1)))
                    pp = ~pp;
                bits[i+j][cnt[i+j]] = pp;
                cnt[i+j]++;
            end
        end
        if (sgn) begin
            bits[WIDTH][cnt[WIDTH]] = 1'b1;
            cnt[WIDTH]++;
            bits[PW-1][cnt[PW-1]] = 1'b1;
            cnt[PW-1]++;
        end

        for (int layer = 0; layer < PW; layer++) begin
            maxh = 0;
            for (int c = 0; c < PW; c++)
                if (cnt[c] > maxh) maxh = cnt[c];
            if (maxh > 2) begin
                for (int c = 0; c < PW; c++) begin
                    ncnt[c] = 0;
                    for (int k = 0; k < H; k++) nxt[c][k] = 1'b0;
                end
                for (int c = 0; c < PW; c++) begin
                    for (int g = 0; g < H / 3; g++) begin
                        if (3 * g + 3 <= cnt[c]) begin
                            nxt[c][ncnt[c]] = bits[c][3*g] ^ bits[c][3*g+1] ^ bits[c][3*g+2];
                            ncnt[c]++;
                            if (c + 1 < PW) begin
                                nxt[c+1][ncnt[c+1]] = (bits[c][3*g]   & bits[c][3*g+1]) |
                                                      (bits[c][3*g]   & bits[c][3*g+2]) |
                                                      (bits[c][3*g+1] & bits[c][3*g+2]);
                                ncnt[c+1]++;
                            end
                        end
                    end
                    base = (cnt[c] / 3) * 3;
                    if (cnt[c] - base == 2) begin
                        nxt[c][ncnt[c]] = bits[c][base] ^ bits[c][base+1];
                        ncnt[c]++;
                        if (c + 1 < PW) begin
                            nxt[c+1][ncnt[c+1]] = bits[c][base] & bits[c][base+1];
                            ncnt[c+1]++;
                        end
                    end else if (cnt[c] - base == 1) begin
                        nxt[c][ncnt[c]] = bits[c][base];
                        ncnt[c]++;
                    end
                end
                for (int c = 0; c < PW; c++) begin
                    cnt[c] = ncnt[c];
                    for (int k = 0; k < H; k++) bits[c][k] = nxt[c][k];
                end
            end
        end

        for (int c = 0; c < PW; c++) begin
            row1[c] = bits[c][0];
            row2[c] = bits[c][1];
        end
        return {row1, row2};
    endfunction

    logic             s1_valid;
    logic             s1_signed;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic [PW-1:0]    s2_r1;
    logic [PW-1:0]    s2_r2;
    logic [PW-1:0]    tree_r1;
    logic [PW-1:0]    tree_r2;
    logic             s2_ready;

    assign {tree_r1, tree_r2} = wallace_tree(s1_a, s1_b, s1_signed);

    assign in_ready = rst || !s1_valid || s2_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_signed <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_signed <= in_signed;
                s1_a      <= a;
                s1_b      <= b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_r1    <= '0;
            s2_r2    <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_r1 <= tree_r1;
                s2_r2 <= tree_r2;
            end
        end
    end

`ifdef WALLACE_MULT_FINAL_ADD_EN
    logic          s3_valid;
    logic [PW-1:0] s3_r1;
    logic [PW-1:0] s3_r2;
    logic [PW-1:0] s3_prod;
    logic          s3_ready;

    assign s3_ready = !s3_valid || out_ready;
    assign s2_ready = !s2_valid || s3_ready;

    // The carry-save rows ride along so they stay aligned with the resolved product.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_r1    <= '0;
            s3_r2    <= '0;
            s3_prod  <= '0;
        end else if (s3_ready) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_r1   <= s2_r1;
                s3_r2   <= s2_r2;
                s3_prod <= s2_r1 + s2_r2;
            end
        end
    end

    assign out_valid = s3_valid;
    assign r1        = s3_r1;
    assign r2        = s3_r2;
    assign prod      = s3_prod;
`else
    assign s2_ready  = !s2_valid || out_ready;
    assign out_valid = s2_valid;
    assign r1        = s2_r1;
    assign r2        = s2_r2;
    assign prod      = '0;
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Randomized and directed checks of wallace_mult_pipe against an arithmetic product model.
// Instantiates WIDTH=5 for the handshake tests and WIDTH=4 for the exhaustive sweep.
module tb_wallace_mult_pipe;

`ifdef WALLACE_MULT_FINAL_ADD_EN
    localparam int LAT   = 3;
    localparam bit FINAL = 1'b1;
`else
    localparam int LAT   = 2;
    localparam bit FINAL = 1'b0;
`endif

    logic       clk;
    logic       rst;

    logic       in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [4:0] a, b;
    logic [9:0] r1, r2, prod;

    logic       in_valid4, in_ready4, in_signed4, out_valid4, out_ready4;
    logic [3:0] a4, b4;
    logic [7:0] r1_4, r2_4, prod4;

    typedef struct {
        logic [63:0] expProd;
        int          cyc;
    } exp_t;

    exp_t        q5[$];
    logic [63:0] q4[$];

    int assertCount = 0;
    int failCount   = 0;
    int cycle       = 0;
    bit accepted5   = 1'b0;
    bit checkLat    = 1'b0;

    wallace_mult_pipe #(.WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .r1(r1), .r2(r2), .prod(prod)
    );

    wallace_mult_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_signed(in_signed4),
        .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .r1(r1_4), .r2(r2_4), .prod(prod4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact product of two w-bit operands, truncated to 2w bits.
    function automatic logic [63:0] refProd(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input bit sgn);
        longint vx, vy, mask;
        vx = longint'(x);
        vy = longint'(y);
        if (sgn && x[w-1]) vx = vx - (longint'(1) << w);
        if (sgn && y[w-1]) vy = vy - (longint'(1) << w);
        mask = (longint'(1) << (2 * w)) - 1;
        return 64'(vx * vy) & 64'(mask);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: record accepted pairs and score delivered results at the falling edge.
    task automatic tick();
        logic [63:0] sum;
        exp_t        e;
        @(negedge clk);
        accepted5 = 1'b0;
        if (rst) begin
            q5.delete();
            q4.delete();
        end else begin
            if (in_valid && in_ready) begin
                q5.push_back('{refProd(5, 32'(a), 32'(b), in_signed), cycle});
                accepted5 = 1'b1;
            end
            if (in_valid4 && in_ready4)
                q4.push_back(refProd(4, 32'(a4), 32'(b4), in_signed4));
            if (out_valid && out_ready) begin
                checkOutput("out_expected", 64'(q5.size() > 0), 64'd1);
                if (q5.size() > 0) begin
                    e   = q5.pop_front();
                    sum = (64'(r1) + 64'(r2)) & 64'h3FF;
                    checkOutput("carry_save_sum", sum, e.expProd);
                    checkOutput("prod", 64'(prod), FINAL ? e.expProd : 64'd0);
                    if (checkLat) checkOutput("latency", 64'(cycle - e.cyc), 64'(LAT));
                end
            end
            if (out_valid4 && out_ready4) begin
                checkOutput("out4_expected", 64'(q4.size() > 0), 64'd1);
                if (q4.size() > 0) begin
                    e.expProd = q4.pop_front();
                    sum = (64'(r1_4) + 64'(r2_4)) & 64'hFF;
                    checkOutput("sweep_sum", sum, e.expProd);
                    checkOutput("sweep_prod", 64'(prod4), FINAL ? e.expProd : 64'd0);
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic [4:0] x, input logic [4:0] y, input logic sgn);
        a         = x;
        b         = y;
        in_signed = sgn;
        in_valid  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (accepted5) break;
        end
        checkOutput("accept", 64'(accepted5), 64'd1);
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        in_valid4  = 1'b0;
        out_ready  = 1'b1;
        out_ready4 = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (q5.size() == 0 && q4.size() == 0) break;
            tick();
        end
        repeat (4) tick();
        checkOutput("drain", 64'(q5.size()), 64'd0);
        checkOutput("drain4", 64'(q4.size()), 64'd0);
    endtask

    initial begin
        logic [4:0] pa, pb;
        logic       ps;
        logic [9:0] heldR1, heldR2, heldProd;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_signed  = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b1;
        in_valid4  = 1'b0;
        in_signed4 = 1'b0;
        a4         = '0;
        b4         = '0;
        out_ready4 = 1'b1;

        tick();
        checkOutput("in_ready_during_reset", 64'(in_ready), 64'd1);
        checkOutput("out_valid_during_reset", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_r1", 64'(r1), 64'd0);
        checkOutput("reset_r2", 64'(r2), 64'd0);
        checkOutput("reset_prod", 64'(prod), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] unsigned 31 x 31");
        checkLat = 1'b1;
        applyStimulus(5'd31, 5'd31, 1'b0);
        drain();

        $display("[TB] signed directed cases");
        applyStimulus(5'b10000, 5'b10000, 1'b1);
        applyStimulus(5'b11111, 5'b00001, 1'b1);
        applyStimulus(5'b00000, 5'b11001, 1'b1);
        drain();

        $display("[TB] back-to-back random pairs");
        for (int i = 0; i < 10; i++)
            applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        drain();

        $display("[TB] output stall");
        checkLat  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < LAT; i++)
            applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        pa = 5'($urandom_range(0, 31));
        pb = 5'($urandom_range(0, 31));
        ps = 1'($urandom_range(0, 1));
        a = pa; b = pb; in_signed = ps; in_valid = 1'b1;
        tick();
        checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
        heldR1   = r1;
        heldR2   = r2;
        heldProd = prod;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("stall_in_ready_hold", 64'(in_ready), 64'd0);
            checkOutput("stall_r1_hold", 64'(r1), 64'(heldR1));
            checkOutput("stall_r2_hold", 64'(r2), 64'(heldR2));
            checkOutput("stall_prod_hold", 64'(prod), 64'(heldProd));
        end
        out_ready = 1'b1;
        applyStimulus(pa, pb, ps);
        applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        drain();

        $display("[TB] reset with transactions in flight");
        out_ready = 1'b0;
        applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_r1", 64'(r1), 64'd0);
        checkOutput("midreset_r2", 64'(r2), 64'd0);
        checkOutput("midreset_prod", 64'(prod), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (6) tick();
        checkLat = 1'b1;
        applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        drain();

        $display("[TB] exhaustive WIDTH=4 sweep");
        checkLat = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    a4         = 4'(x);
                    b4         = 4'(y);
                    in_signed4 = 1'(s);
                    in_valid4  = 1'b1;
                    tick();
                end
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
